// File: rtl/ddr_app_arbiter.sv
// rtl/ddr_app_arbiter.sv - weighted round-robin arbiter sharing the MIG app interface between a writer and a reader
//
// Purpose:
//   Grants the single MIG user command interface to either the write requester
//   (command + one full 512-bit data beat issued together) or the read
//   requester. Each owner may take up to BURST_MAX consecutive accepts while
//   the other side waits, and keeps streaming if the other side is idle.
//   Outstanding reads are tracked and read issue stops at MAX_RD_OUT.
//
// Optional feature macro: ARB_STATS_EN
//   defined   -> 32-bit accept/stall statistics counters are built
//   undefined -> stat_* outputs tied to 0, arbitration unchanged
//
// Ports:
//   clk, resetn                 MIG user clock, synchronous active-low reset
//   init_calib_complete         no command is issued while low
//   wr_valid/addr/data/mask     write request (held until wr_ready)
//   wr_ready                    write accepted this cycle
//   rd_valid/rd_addr, rd_ready  read request / accepted this cycle
//   rd_data, rd_data_valid      pass-through of the MIG read return
//   app_rdy, app_wdf_rdy        MIG command / write-data ready
//   app_en/cmd/addr             MIG command (cmd 000 write, 001 read)
//   app_wdf_wren/end/data/mask  MIG write data
//   app_rd_data/_valid/_end     MIG read return
//   stat_wr_cnt/rd_cnt/stall_cnt statistics

module ddr_app_arbiter #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 512,
  parameter int MASK_WIDTH = 64,
  parameter int BURST_MAX  = 8,
  parameter int MAX_RD_OUT = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  init_calib_complete,
  input  logic                  wr_valid,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [MASK_WIDTH-1:0] wr_mask,
  output logic                  wr_ready,
  input  logic                  rd_valid,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  input  logic                  app_rdy,
  input  logic                  app_wdf_rdy,
  output logic                  app_en,
  output logic [2:0]            app_cmd,
  output logic [ADDR_WIDTH-1:0] app_addr,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  output logic [DATA_WIDTH-1:0] app_wdf_data,
  output logic [MASK_WIDTH-1:0] app_wdf_mask,
  input  logic [DATA_WIDTH-1:0] app_rd_data,
  input  logic                  app_rd_data_valid,
  input  logic                  app_rd_data_end,
  output logic [31:0]           stat_wr_cnt,
  output logic [31:0]           stat_rd_cnt,
  output logic [31:0]           stat_stall_cnt
);

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int OW = $clog2(MAX_RD_OUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [OW-1:0]   rd_out_q, rd_out_d;
  logic            last_rd_q, last_rd_d;  // 1: last owner was the reader

  logic active;
  logic in_wr, in_rd;
  logic rd_room, rd_elig;
  logic wr_issue, rd_issue;
  logic rd_ret;
  logic burst_hit;
  logic [BW-1:0] burst_inc;

  // Gating with resetn drops any handshake that coincides with a reset cycle.
  assign active   = resetn & init_calib_complete;
  assign in_wr    = active & (state_q == S_WR);
  assign in_rd    = active & (state_q == S_RD);
  assign rd_room  = int'(rd_out_q) < MAX_RD_OUT;
  assign rd_elig  = rd_valid & rd_room;

  // Write command and data are only offered together, so app_wdf_rdy gates app_en.
  assign wr_issue = in_wr & wr_valid & app_wdf_rdy;
  assign rd_issue = in_rd & rd_valid & rd_room;

  assign app_en       = wr_issue | rd_issue;
  assign app_cmd      = in_rd ? 3'b001 : 3'b000;
  assign app_wdf_wren = wr_issue;
  assign app_wdf_end  = wr_issue;
  assign app_addr     = in_wr ? wr_addr : (in_rd ? rd_addr : '0);
  assign app_wdf_data = in_wr ? wr_data : '0;
  assign app_wdf_mask = in_wr ? wr_mask : '0;
  assign wr_ready     = wr_issue & app_rdy;
  assign rd_ready     = rd_issue & app_rdy;

  assign rd_data       = app_rd_data;
  assign rd_data_valid = app_rd_data_valid;

  // Returns arriving with nothing outstanding are ignored (e.g. after a reset).
  assign rd_ret    = app_rd_data_valid & app_rd_data_end & (rd_out_q != '0);
  assign burst_hit = (int'(burst_q) + 1) >= BURST_MAX;
  assign burst_inc = (int'(burst_q) >= BURST_MAX) ? burst_q : burst_q + BW'(1);

  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    last_rd_d = last_rd_q;

    case (state_q)
      S_IDLE: begin
        if (init_calib_complete) begin
          if (wr_valid && rd_elig) state_d = last_rd_q ? S_WR : S_RD;
          else if (wr_valid)       state_d = S_WR;
          else if (rd_elig)        state_d = S_RD;
        end
      end
      S_WR: begin
        if (!init_calib_complete) begin
          state_d   = S_IDLE;
          burst_d   = '0;
          last_rd_d = 1'b0;
        end else if (!wr_valid || (wr_ready && burst_hit && rd_elig)) begin
          state_d   = rd_elig ? S_RD : S_IDLE;
          burst_d   = '0;
          last_rd_d = 1'b0;
        end else if (wr_ready) begin
          burst_d = burst_inc;
        end
      end
      S_RD: begin
        // A full outstanding window only forces a hand-over if the writer wants in.
        if (!init_calib_complete) begin
          state_d   = S_IDLE;
          burst_d   = '0;
          last_rd_d = 1'b1;
        end else if (!rd_valid || (!rd_room && wr_valid) ||
                     (rd_ready && burst_hit && wr_valid)) begin
          state_d   = wr_valid ? S_WR : S_IDLE;
          burst_d   = '0;
          last_rd_d = 1'b1;
        end else if (rd_ready) begin
          burst_d = burst_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        burst_d = '0;
      end
    endcase

    rd_out_d = rd_out_q;
    if (rd_ready && !rd_ret)      rd_out_d = rd_out_q + OW'(1);
    else if (!rd_ready && rd_ret) rd_out_d = rd_out_q - OW'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      burst_q   <= '0;
      rd_out_q  <= '0;
      last_rd_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      rd_out_q  <= rd_out_d;
      last_rd_q <= last_rd_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [31:0] stat_wr_q, stat_rd_q, stat_stall_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stat_wr_q    <= '0;
      stat_rd_q    <= '0;
      stat_stall_q <= '0;
    end else begin
      if (wr_ready)           stat_wr_q    <= stat_wr_q + 32'd1;
      if (rd_ready)           stat_rd_q    <= stat_rd_q + 32'd1;
      if (app_en && !app_rdy) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_wr_cnt    = stat_wr_q;
  assign stat_rd_cnt    = stat_rd_q;
  assign stat_stall_cnt = stat_stall_q;
`else
  assign stat_wr_cnt    = '0;
  assign stat_rd_cnt    = '0;
  assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ddr_app_arbiter.sv
// tb/tb_ddr_app_arbiter.sv - self-checking bench for ddr_app_arbiter
module tb_ddr_app_arbiter;

  localparam int AW  = 28;
  localparam int DW  = 512;
  localparam int MW  = 64;
  localparam int BM  = 4;
  localparam int MRO = 16;

`ifdef ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn, calib;
  logic          wr_valid, wr_ready, rd_valid, rd_ready;
  logic [AW-1:0] wr_addr, rd_addr, app_addr;
  logic [DW-1:0] wr_data, rd_data, app_wdf_data, app_rd_data;
  logic [MW-1:0] wr_mask, app_wdf_mask;
  logic          rd_data_valid, app_rdy, app_wdf_rdy, app_en;
  logic [2:0]    app_cmd;
  logic          app_wdf_wren, app_wdf_end, app_rd_data_valid, app_rd_data_end;
  logic [31:0]   stat_wr_cnt, stat_rd_cnt, stat_stall_cnt;

  ddr_app_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
    .BURST_MAX(BM), .MAX_RD_OUT(MRO)
  ) dut (
    .clk(clk), .resetn(resetn), .init_calib_complete(calib),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .wr_ready(wr_ready), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_en(app_en), .app_cmd(app_cmd),
    .app_addr(app_addr), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end),
    .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt), .stat_stall_cnt(stat_stall_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [AW-1:0] wr_src[$], rd_src[$], exp_wr[$], exp_rd[$];

  logic          s_en, s_wr, s_rd, s_wren, s_end, s_rdv;
  logic [2:0]    s_cmd;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_data, s_rdata;
  logic [MW-1:0] s_mask;

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return {16{32'(a) ^ 32'hA5C3_0F00}};
  endfunction

  function automatic logic [MW-1:0] mask_of(input logic [AW-1:0] a);
    return {32'(a), ~32'(a)};
  endfunction

  task automatic drive();
    wr_valid = (wr_src.size() != 0);
    wr_addr  = wr_valid ? wr_src[0] : '0;
    wr_data  = data_of(wr_addr);
    wr_mask  = mask_of(wr_addr);
    rd_valid = (rd_src.size() != 0);
    rd_addr  = rd_valid ? rd_src[0] : '0;
  endtask

  // Sample one cycle on the falling edge, then advance the requesters after the rising edge.
  task automatic step();
    @(negedge clk);
    s_en = app_en;   s_wr = wr_ready;  s_rd = rd_ready;   s_wren = app_wdf_wren;
    s_end = app_wdf_end; s_cmd = app_cmd; s_addr = app_addr; s_data = app_wdf_data;
    s_mask = app_wdf_mask; s_rdv = rd_data_valid; s_rdata = rd_data;
    @(posedge clk);
    #1;
    if (s_wr && wr_src.size() != 0) void'(wr_src.pop_front());
    if (s_rd && rd_src.size() != 0) void'(rd_src.pop_front());
    drive();
  endtask

  task automatic do_reset();
    resetn = 1'b0; calib = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0; app_rd_data = '0;
    wr_src.delete(); rd_src.delete(); exp_wr.delete(); exp_rd.delete();
    drive();
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; calib = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0; app_rd_data = '0;
    wr_valid = 1'b1; wr_addr = 28'h0000123; wr_data = data_of(28'h0000123); wr_mask = mask_of(28'h0000123);
    rd_valid = 1'b1; rd_addr = 28'h0000456;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({app_en, app_wdf_wren, app_wdf_end, wr_ready, rd_ready} !== 5'b0 || app_addr !== '0 ||
          app_wdf_data !== '0 || app_wdf_mask !== '0 || app_cmd !== 3'b0 ||
          stat_wr_cnt !== 0 || stat_rd_cnt !== 0 || stat_stall_cnt !== 0) begin
        n_err++;
        $display("FAIL reset_outputs: en=%b wren=%b wr_ready=%b rd_ready=%b addr=%h, required all 0",
                 app_en, app_wdf_wren, wr_ready, rd_ready, app_addr);
      end
    end
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    n_vec++;
    if (app_en !== 1'b0) begin
      n_err++;
      $display("FAIL reset_bubble: app_en=%b, required 0", app_en);
    end
    @(negedge clk);
    n_vec++;
    if (app_en !== 1'b1 || app_cmd !== 3'b000 || wr_ready !== 1'b1 || app_addr !== 28'h0000123) begin
      n_err++;
      $display("FAIL reset_first_issue: en=%b cmd=%0d wr_ready=%b addr=%h, required en=1 cmd=0 wr_ready=1 addr=0000123",
               app_en, app_cmd, wr_ready, app_addr);
    end
  endtask

  task automatic test_write_stream();
    int first = -1;
    int last  = -1;
    int nacc  = 0;
    logic [AW-1:0] e;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      wr_src.push_back(AW'(28'h0100000 + i * 8));
      exp_wr.push_back(AW'(28'h0100000 + i * 8));
    end
    drive();
    for (int c = 0; c < 60 && exp_wr.size() != 0; c++) begin
      step();
      if (s_wr) begin
        e = exp_wr.pop_front();
        n_vec++;
        if (s_addr !== e || s_data !== data_of(e) || s_mask !== mask_of(e) ||
            s_end !== 1'b1 || s_wren !== 1'b1 || s_cmd !== 3'b000) begin
          n_err++;
          $display("FAIL wr_stream beat %0d: addr=%h end=%b wren=%b cmd=%0d, required addr=%h end=1 wren=1 cmd=0",
                   nacc, s_addr, s_end, s_wren, s_cmd, e);
        end
        if (first < 0) first = c;
        last = c;
        nacc++;
      end
    end
    n_vec++;
    if (nacc != 20 || last - first != 19) begin
      n_err++;
      $display("FAIL wr_stream_count: accepts=%0d span=%0d, required 20 accepts over 19 cycles", nacc, last - first);
    end
  endtask

  task automatic test_burst();
    int idx = 0;
    bit started = 0;
    logic exp_is_wr;
    logic [AW-1:0] e;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      wr_src.push_back(AW'(28'h0200000 + i)); exp_wr.push_back(AW'(28'h0200000 + i));
      rd_src.push_back(AW'(28'h0300000 + i)); exp_rd.push_back(AW'(28'h0300000 + i));
    end
    drive();
    for (int c = 0; c < 80 && idx < 24; c++) begin
      step();
      if (s_wr || s_rd) begin
        started = 1;
        exp_is_wr = ((idx / BM) % 2) == 0;
        e = '0;
        if (s_wr && exp_wr.size() != 0) e = exp_wr.pop_front();
        if (s_rd && !s_wr && exp_rd.size() != 0) e = exp_rd.pop_front();
        n_vec++;
        if (s_wr !== exp_is_wr || (s_wr && s_rd) || s_addr !== e || s_cmd !== (s_wr ? 3'b000 : 3'b001)) begin
          n_err++;
          $display("FAIL burst_order idx %0d: wr=%b rd=%b addr=%h cmd=%0d, required wr=%b addr=%h",
                   idx, s_wr, s_rd, s_addr, s_cmd, exp_is_wr, e);
        end
        idx++;
      end else if (started) begin
        n_vec++;
        n_err++;
        $display("FAIL burst_gap: idle cycle before accept %0d, required none", idx);
      end
    end
    n_vec++;
    if (idx != 24) begin
      n_err++;
      $display("FAIL burst_count: accepts=%0d, required 24", idx);
    end
  endtask

  task automatic test_rd_throttle();
    int cnt = 0;
    logic [AW-1:0] e;
    logic [DW-1:0] pat;
    pat = {16{32'hDEAD_BEEF}};
    do_reset();
    // A return with nothing outstanding must not open extra read credit.
    app_rd_data = pat; app_rd_data_valid = 1'b1; app_rd_data_end = 1'b1;
    step();
    app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
    n_vec++;
    if (s_rdv !== 1'b1 || s_rdata !== pat) begin
      n_err++;
      $display("FAIL rd_passthrough: rd_data_valid=%b low_word=%h, required 1 and deadbeef", s_rdv, s_rdata[31:0]);
    end
    for (int i = 0; i < 20; i++) begin
      rd_src.push_back(AW'(28'h0400000 + i * 2)); exp_rd.push_back(AW'(28'h0400000 + i * 2));
    end
    drive();
    for (int c = 0; c < 40; c++) begin
      step();
      if (s_rd) begin
        e = exp_rd.pop_front();
        n_vec++;
        if (s_addr !== e || s_cmd !== 3'b001) begin
          n_err++;
          $display("FAIL rd_addr read %0d: addr=%h cmd=%0d, required addr=%h cmd=1", cnt, s_addr, s_cmd, e);
        end
        cnt++;
      end
    end
    n_vec++;
    if (cnt != MRO || s_en !== 1'b0) begin
      n_err++;
      $display("FAIL rd_throttle: reads=%0d app_en=%b, required %0d reads then app_en=0", cnt, s_en, MRO);
    end
    // valid without end is not a completed return
    cnt = 0;
    app_rd_data_valid = 1'b1;
    step();
    app_rd_data_valid = 1'b0;
    repeat (5) begin
      step();
      if (s_rd) cnt++;
    end
    n_vec++;
    if (cnt != 0) begin
      n_err++;
      $display("FAIL rd_noend_return: reads=%0d, required 0", cnt);
    end
    app_rd_data_valid = 1'b1; app_rd_data_end = 1'b1;
    step();
    if (s_rd) cnt++;
    app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
    repeat (10) begin
      step();
      if (s_rd) cnt++;
    end
    n_vec++;
    if (cnt != 1) begin
      n_err++;
      $display("FAIL rd_one_return: reads=%0d, required 1", cnt);
    end
    n_vec++;
    if (stat_rd_cnt !== (STATS ? 32'd17 : 32'd0)) begin
      n_err++;
      $display("FAIL stat_rd_cnt: got %0d, required %0d", stat_rd_cnt, STATS ? 17 : 0);
    end
  endtask

  task automatic test_stall();
    int nacc = 0;
    logic [AW-1:0] e;
    do_reset();
    app_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_src.push_back(AW'(28'h0500000 + i)); exp_wr.push_back(AW'(28'h0500000 + i));
    end
    drive();
    step();
    n_vec++;
    if (s_en !== 1'b0) begin
      n_err++;
      $display("FAIL stall_bubble: app_en=%b, required 0", s_en);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      n_vec++;
      if (s_en !== 1'b1 || s_wr !== 1'b0 || s_addr !== exp_wr[0] || s_data !== data_of(exp_wr[0])) begin
        n_err++;
        $display("FAIL stall_hold cycle %0d: en=%b wr_ready=%b addr=%h, required en=1 wr_ready=0 addr=%h",
                 k, s_en, s_wr, s_addr, exp_wr[0]);
      end
    end
    app_rdy = 1'b1;
    for (int c = 0; c < 20 && exp_wr.size() != 0; c++) begin
      step();
      if (s_wr) begin
        e = exp_wr.pop_front();
        nacc++;
        n_vec++;
        if (s_addr !== e) begin
          n_err++;
          $display("FAIL stall_resume addr: got %h, required %h", s_addr, e);
        end
      end
    end
    n_vec++;
    if (nacc != 4 || stat_stall_cnt !== (STATS ? 32'd5 : 32'd0) || stat_wr_cnt !== (STATS ? 32'd4 : 32'd0)) begin
      n_err++;
      $display("FAIL stall_stats: accepts=%0d stall=%0d wr_cnt=%0d, required 4 accepts stall=%0d wr_cnt=%0d",
               nacc, stat_stall_cnt, stat_wr_cnt, STATS ? 5 : 0, STATS ? 4 : 0);
    end
  endtask

  task automatic test_calib();
    int nwr = 0;
    bit seen = 0;
    do_reset();
    calib = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_src.push_back(AW'(28'h0600000 + i));
      rd_src.push_back(AW'(28'h0700000 + i));
    end
    drive();
    repeat (6) begin
      step();
      n_vec++;
      if (s_en !== 1'b0 || s_wr !== 1'b0 || s_rd !== 1'b0) begin
        n_err++;
        $display("FAIL calib_low_issue: en=%b wr_ready=%b rd_ready=%b, required all 0", s_en, s_wr, s_rd);
      end
    end
    calib = 1'b1;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      if (s_wr || s_rd) begin
        seen = 1;
        n_vec++;
        if (s_wr !== 1'b1 || s_rd !== 1'b0) begin
          n_err++;
          $display("FAIL calib_first_owner: wr=%b rd=%b, required write first", s_wr, s_rd);
        end
        if (s_wr) nwr++;
      end
    end
    for (int c = 0; c < 10 && nwr < 2; c++) begin
      step();
      if (s_wr) nwr++;
    end
    n_vec++;
    if (nwr != 2) begin
      n_err++;
      $display("FAIL calib_writes: writes=%0d, required 2", nwr);
    end
    calib = 1'b0;
    step();
    repeat (3) begin
      step();
      n_vec++;
      if (s_en !== 1'b0) begin
        n_err++;
        $display("FAIL calib_drop: app_en=%b, required 0", s_en);
      end
    end
    calib = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      if (s_wr || s_rd) seen = 1;
    end
    n_vec++;
    if (!seen || s_rd !== 1'b1 || s_wr !== 1'b0) begin
      n_err++;
      $display("FAIL calib_resume_owner: seen=%0d wr=%b rd=%b, required read first", seen, s_wr, s_rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_stream();
    test_burst();
    test_rd_throttle();
    test_stall();
    test_calib();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
